// File: rtl/fwd_bypass_unit_pkg.sv
// Shared types for the EX-stage operand bypass network: forwarding source
// encoding, load-use FSM states and the retired-write history entry.
package fwd_bypass_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STATS_W    = 32;

  typedef enum logic [1:0] {
    FW_NONE    = 2'd0,
    FW_MEM_ALU = 2'd1,
    FW_WB_DATA = 2'd2,
    FW_HIST    = 2'd3
  } fw_sel_e;

  typedef enum logic {
    LU_IDLE  = 1'b0,
    LU_STALL = 1'b1
  } lu_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_bypass_unit_if.sv
// Pipeline-side bundle of the bypass unit: ID/EX operands, EX/MEM and MEM/WB
// write-back info in, forwarded operands and load-use stall out.
interface fwd_bypass_unit_if #(
  parameter int DATA_WIDTH = fwd_bypass_unit_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = fwd_bypass_unit_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = 2
);
  import fwd_bypass_unit_pkg::*;

  logic                           flush_i;
  logic                           id_ex_valid_i;
  logic [NUM_SRC*REG_ADDR_W-1:0]  rs_addr_i;
  logic [NUM_SRC*DATA_WIDTH-1:0]  rs_data_i;
  logic                           ex_mem_valid_i;
  logic                           ex_mem_reg_wr_i;
  logic                           ex_mem_is_load_i;
  logic [REG_ADDR_W-1:0]          ex_mem_rd_i;
  logic [DATA_WIDTH-1:0]          ex_mem_alu_i;
  logic                           mem_wb_valid_i;
  logic                           mem_wb_reg_wr_i;
  logic [REG_ADDR_W-1:0]          mem_wb_rd_i;
  logic [DATA_WIDTH-1:0]          mem_wb_data_i;
  logic [NUM_SRC*DATA_WIDTH-1:0]  operand_o;
  fw_sel_e [NUM_SRC-1:0]          fw_sel_o;
  logic                           load_use_stall_o;

  modport master (
    output flush_i, id_ex_valid_i, rs_addr_i, rs_data_i,
           ex_mem_valid_i, ex_mem_reg_wr_i, ex_mem_is_load_i, ex_mem_rd_i, ex_mem_alu_i,
           mem_wb_valid_i, mem_wb_reg_wr_i, mem_wb_rd_i, mem_wb_data_i,
    input  operand_o, fw_sel_o, load_use_stall_o
  );

  modport slave (
    input  flush_i, id_ex_valid_i, rs_addr_i, rs_data_i,
           ex_mem_valid_i, ex_mem_reg_wr_i, ex_mem_is_load_i, ex_mem_rd_i, ex_mem_alu_i,
           mem_wb_valid_i, mem_wb_reg_wr_i, mem_wb_rd_i, mem_wb_data_i,
    output operand_o, fw_sel_o, load_use_stall_o
  );

endinterface

// File: rtl/fwd_bypass_unit_hist_buf.sv
// fwd_hist_buf: shift register of recently retired register writes, covering
// the gap between MEM/WB and the register file read. Entry 0 is the newest;
// each lookup port returns the newest matching entry.
module fwd_hist_buf
  import fwd_bypass_unit_pkg::*;
#(
  parameter int HIST_DEPTH = 2,
  parameter int NUM_SRC    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [REG_ADDR_W-1:0]         push_rd_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] lk_rd_i,
  output logic [NUM_SRC-1:0]            hit_o,
  output logic [NUM_SRC*DATA_WIDTH-1:0] data_o
);

  logic [HIST_DEPTH-1:0] vld_q;
  logic [REG_ADDR_W-1:0] rd_q   [HIST_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [HIST_DEPTH];
  hist_entry_t           ent    [HIST_DEPTH];

  // Valid bits are the only reset state; payload is qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (push_i) begin
      vld_q[0] <= 1'b1;
      for (int i = 1; i < HIST_DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload shifts alongside the valid bits, oldest entry falls off the end.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[0]   <= push_rd_i;
      data_q[0] <= push_data_i;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        rd_q[i]   <= rd_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // Assemble entries and search oldest->newest so the newest match wins.
  always_comb begin
    hit_o  = '0;
    data_o = '0;
    for (int i = 0; i < HIST_DEPTH; i++) ent[i] = '{valid: vld_q[i], rd: rd_q[i], data: data_q[i]};
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = HIST_DEPTH-1; i >= 0; i--) begin
        if (ent[i].valid && ent[i].rd == lk_rd_i[s*REG_ADDR_W +: REG_ADDR_W]) begin
          hit_o[s]                         = 1'b1;
          data_o[s*DATA_WIDTH +: DATA_WIDTH] = ent[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: EX-stage operand bypass. Per operand picks the freshest of
// EX/MEM ALU result, MEM/WB data, retired-write history, or regfile data, and
// raises a one-cycle load-use stall.
// Optional build macro FWD_BYPASS_STATS_EN adds saturating forwarding/stall
// counters on stats_o with synchronous clear stats_clr_i.
module fwd_bypass_unit #(
  parameter int DATA_WIDTH = fwd_bypass_unit_pkg::DATA_WIDTH,
  parameter int REG_ADDR_W = fwd_bypass_unit_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FWD_BYPASS_STATS_EN
  input  logic                stats_clr_i,
  output logic [4*32-1:0]     stats_o,
`endif
  fwd_bypass_unit_if.slave    bus
);
  import fwd_bypass_unit_pkg::*;

  logic [NUM_SRC-1:0]            ld_hit;
  logic [NUM_SRC-1:0]            hist_hit;
  logic [NUM_SRC*DATA_WIDTH-1:0] hist_data;
  logic                          ex_mem_wr;
  logic                          mem_wb_wr;
  logic                          ld_use;
  logic                          stall;
  lu_state_e                     state_q;
  logic                          active_q;

  assign ex_mem_wr = bus.ex_mem_valid_i & bus.ex_mem_reg_wr_i;
  assign mem_wb_wr = bus.mem_wb_valid_i & bus.mem_wb_reg_wr_i;

  fwd_hist_buf #(
    .HIST_DEPTH (HIST_DEPTH),
    .NUM_SRC    (NUM_SRC)
  ) u_hist (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (mem_wb_wr & (bus.mem_wb_rd_i != '0)),
    .push_rd_i   (bus.mem_wb_rd_i),
    .push_data_i (bus.mem_wb_data_i),
    .lk_rd_i     (bus.rs_addr_i),
    .hit_o       (hist_hit),
    .data_o      (hist_data)
  );

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  nz;
    logic                  exm_hit;
    logic                  wb_hit;
    logic [DATA_WIDTH-1:0] opnd;
    fw_sel_e               sel;

    assign rs        = bus.rs_addr_i[s*REG_ADDR_W +: REG_ADDR_W];
    assign nz        = (rs != '0);
    assign exm_hit   = ex_mem_wr & (bus.ex_mem_rd_i == rs) & nz;
    assign wb_hit    = mem_wb_wr & (bus.mem_wb_rd_i == rs) & nz;
    assign ld_hit[s] = exm_hit & bus.ex_mem_is_load_i;

    // Priority select; a load in EX/MEM has no data yet, so it never forwards.
    always_comb begin
      sel  = FW_NONE;
      opnd = bus.rs_data_i[s*DATA_WIDTH +: DATA_WIDTH];
      if (exm_hit && !bus.ex_mem_is_load_i) begin
        sel  = FW_MEM_ALU;
        opnd = bus.ex_mem_alu_i;
      end else if (wb_hit) begin
        sel  = FW_WB_DATA;
        opnd = bus.mem_wb_data_i;
      end else if (hist_hit[s] && nz) begin
        sel  = FW_HIST;
        opnd = hist_data[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign bus.operand_o[s*DATA_WIDTH +: DATA_WIDTH] = opnd;
    assign bus.fw_sel_o[s]                           = sel;
  end

  assign ld_use               = bus.id_ex_valid_i & (|ld_hit);
  assign stall                = active_q & (state_q == LU_IDLE) & ld_use & ~bus.flush_i;
  assign bus.load_use_stall_o = stall;

  // Load-use FSM: one stall cycle, then the load has reached MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LU_IDLE;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        LU_IDLE:  state_q <= stall ? LU_STALL : LU_IDLE;
        default:  state_q <= LU_IDLE;
      endcase
    end
  end

`ifdef FWD_BYPASS_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  logic [31:0] n_mem, n_wb, n_hist;
  logic [31:0] cnt_mem, cnt_wb, cnt_hist, cnt_stall;

  // Number of operands taking each forwarding source this cycle.
  always_comb begin
    n_mem  = '0;
    n_wb   = '0;
    n_hist = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.fw_sel_o[s] == FW_MEM_ALU) n_mem  = n_mem  + 32'd1;
      if (bus.fw_sel_o[s] == FW_WB_DATA) n_wb   = n_wb   + 32'd1;
      if (bus.fw_sel_o[s] == FW_HIST)    n_hist = n_hist + 32'd1;
    end
  end

  // Saturating counters, clear takes precedence over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_mem   <= '0;
      cnt_wb    <= '0;
      cnt_hist  <= '0;
      cnt_stall <= '0;
    end else if (stats_clr_i) begin
      cnt_mem   <= '0;
      cnt_wb    <= '0;
      cnt_hist  <= '0;
      cnt_stall <= '0;
    end else begin
      if (bus.id_ex_valid_i) begin
        cnt_mem  <= sat_add(cnt_mem, n_mem);
        cnt_wb   <= sat_add(cnt_wb, n_wb);
        cnt_hist <= sat_add(cnt_hist, n_hist);
      end
      if (stall) cnt_stall <= sat_add(cnt_stall, 32'd1);
    end
  end

  assign stats_o = {cnt_mem, cnt_wb, cnt_hist, cnt_stall};
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed bench for fwd_bypass_unit: reset masking, forwarding priority,
// x0 handling, load-use stall, history lookup/eviction, flush and async reset.
module tb_fwd_bypass_unit;
  import fwd_bypass_unit_pkg::*;

  localparam int DW = 32;
  localparam int RA = 5;
  localparam int NS = 2;
  localparam int HD = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fwd_bypass_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_W(RA), .NUM_SRC(NS)) bus ();

`ifdef FWD_BYPASS_STATS_EN
  logic         stats_clr;
  logic [127:0] stats;
`endif

  fwd_bypass_unit #(
    .DATA_WIDTH (DW),
    .REG_ADDR_W (RA),
    .NUM_SRC    (NS),
    .HIST_DEPTH (HD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FWD_BYPASS_STATS_EN
    .stats_clr_i (stats_clr),
    .stats_o     (stats),
`endif
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] op(input int s);
    return bus.operand_o[s*DW +: DW];
  endfunction

  function automatic logic [31:0] sel(input int s);
    return 32'(bus.fw_sel_o[s]);
  endfunction

  function automatic logic [31:0] stl();
    return 32'(bus.load_use_stall_o);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rs(input int s, input logic [RA-1:0] a, input logic [DW-1:0] d);
    bus.rs_addr_i[s*RA +: RA] = a;
    bus.rs_data_i[s*DW +: DW] = d;
  endtask

  task automatic set_exm(input logic v, input logic wr, input logic ld,
                         input logic [RA-1:0] rd, input logic [DW-1:0] alu);
    bus.ex_mem_valid_i   = v;
    bus.ex_mem_reg_wr_i  = wr;
    bus.ex_mem_is_load_i = ld;
    bus.ex_mem_rd_i      = rd;
    bus.ex_mem_alu_i     = alu;
  endtask

  task automatic set_wb(input logic v, input logic wr, input logic [RA-1:0] rd, input logic [DW-1:0] d);
    bus.mem_wb_valid_i  = v;
    bus.mem_wb_reg_wr_i = wr;
    bus.mem_wb_rd_i     = rd;
    bus.mem_wb_data_i   = d;
  endtask

  task automatic idle();
    bus.flush_i       = 1'b0;
    bus.id_ex_valid_i = 1'b0;
    set_rs(0, '0, '0);
    set_rs(1, '0, '0);
    set_exm(1'b0, 1'b0, 1'b0, '0, '0);
    set_wb(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
`ifdef FWD_BYPASS_STATS_EN
    stats_clr = 1'b0;
`endif
    // Reset: load-use present but stall masked, operands follow inputs
    bus.id_ex_valid_i = 1'b1;
    set_rs(0, 5'd9, 32'h55);
    set_rs(1, 5'd7, 32'h0);
    set_exm(1'b1, 1'b1, 1'b1, 5'd7, 32'h1000);
    settle();
    chk("rst_stall", stl(), 32'd0);
    chk("rst_op0", op(0), 32'h55);
    chk("rst_sel0", sel(0), 32'(FW_NONE));
    chk("rst_sel1_load_excl", sel(1), 32'(FW_NONE));
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("rel_stall_first_cycle", stl(), 32'd0);
    tick();
    chk("rel_stall_active", stl(), 32'd1);
    idle();
    tick();

    // 1: EX/MEM ALU forward
    bus.id_ex_valid_i = 1'b1;
    set_exm(1'b1, 1'b1, 1'b0, 5'd5, 32'h11);
    set_rs(0, 5'd5, 32'h99);
    set_rs(1, 5'd0, 32'h77);
    settle();
    chk("s1_op0", op(0), 32'h11);
    chk("s1_sel0", sel(0), 32'(FW_MEM_ALU));
    chk("s1_stall", stl(), 32'd0);
    chk("s1_op1", op(1), 32'h77);
    chk("s1_sel1", sel(1), 32'(FW_NONE));
    tick();

    // 2: EX/MEM beats MEM/WB; x0 never forwards
    set_wb(1'b1, 1'b1, 5'd5, 32'h22);
    settle();
    chk("s2_prio_op0", op(0), 32'h11);
    chk("s2_prio_sel0", sel(0), 32'(FW_MEM_ALU));
    tick();
    set_exm(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD);
    set_wb(1'b1, 1'b1, 5'd0, 32'hBEEF);
    set_rs(0, 5'd0, 32'h33);
    settle();
    chk("s2_x0_op0", op(0), 32'h33);
    chk("s2_x0_sel0", sel(0), 32'(FW_NONE));
    tick();

    // 3: load-use stall for one cycle, then forward from MEM/WB
    idle();
    bus.id_ex_valid_i = 1'b1;
    set_exm(1'b1, 1'b1, 1'b1, 5'd7, 32'h1000);
    set_rs(1, 5'd7, 32'h0);
    settle();
    chk("s3_stall", stl(), 32'd1);
    chk("s3_sel1_no_memalu", sel(1), 32'(FW_NONE));
    chk("s3_op1", op(1), 32'h0);
    tick();
    set_wb(1'b1, 1'b1, 5'd7, 32'hAB);
    settle();
    chk("s3_no_restall", stl(), 32'd0);
    chk("s3_op1_wb", op(1), 32'hAB);
    chk("s3_sel1_wb", sel(1), 32'(FW_WB_DATA));
    tick();

    // 4: history forward, newest duplicate wins, eviction
    idle();
    set_wb(1'b1, 1'b1, 5'd3, 32'h1);
    tick();
    set_wb(1'b1, 1'b1, 5'd3, 32'h2);
    set_rs(0, 5'd3, 32'h0);
    settle();
    chk("s4_wb_over_hist_op0", op(0), 32'h2);
    chk("s4_wb_over_hist_sel0", sel(0), 32'(FW_WB_DATA));
    tick();
    set_wb(1'b1, 1'b1, 5'd4, 32'h44);
    settle();
    chk("s4_dup_op0", op(0), 32'h2);
    chk("s4_dup_sel0", sel(0), 32'(FW_HIST));
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    bus.id_ex_valid_i = 1'b1;
    settle();
    chk("s4_hist_op0", op(0), 32'h2);
    chk("s4_hist_sel0", sel(0), 32'(FW_HIST));
    tick();
    bus.id_ex_valid_i = 1'b0;
    set_wb(1'b1, 1'b1, 5'd10, 32'hA0);
    tick();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0);
    set_rs(1, 5'd4, 32'h9);
    settle();
    chk("s4_evict_op0", op(0), 32'h0);
    chk("s4_evict_sel0", sel(0), 32'(FW_NONE));
    chk("s4_hist_op1", op(1), 32'h44);
    chk("s4_hist_sel1", sel(1), 32'(FW_HIST));

`ifdef FWD_BYPASS_STATS_EN
    // 6: counters after scenarios 1-4, then clear
    chk("st_mem_alu", stats[127:96], 32'd2);
    chk("st_wb", stats[95:64], 32'd1);
    chk("st_hist", stats[63:32], 32'd1);
    chk("st_stall", stats[31:0], 32'd1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr_mem_alu", stats[127:96], 32'd0);
    chk("st_clr_wb", stats[95:64], 32'd0);
    chk("st_clr_hist", stats[63:32], 32'd0);
    chk("st_clr_stall", stats[31:0], 32'd0);
`endif

    // 5: flush suppresses stall and keeps FSM idle
    idle();
    bus.id_ex_valid_i = 1'b1;
    set_exm(1'b1, 1'b1, 1'b1, 5'd7, 32'h2000);
    set_rs(1, 5'd7, 32'h5);
    bus.flush_i = 1'b1;
    settle();
    chk("s5_flush_stall", stl(), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    settle();
    chk("s5_idle_after_flush", stl(), 32'd1);
    // Async reset while stalling
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_rst_stall", stl(), 32'd0);
    chk("s5_rst_op1", op(1), 32'h5);
    set_rs(0, 5'd10, 32'h66);
    settle();
    chk("s5_hist_cleared_sel0", sel(0), 32'(FW_NONE));
    chk("s5_hist_cleared_op0", op(0), 32'h66);
    tick();
    rst_n = 1'b1;
    settle();
    chk("s5_rel_stall_first", stl(), 32'd0);
    tick();
    chk("s5_rel_stall_active", stl(), 32'd1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
